// File: rtl/mult_control_unit.sv
// Control FSM for the 8-bit signed add-shift multiplier: sequences CLR, then N
// add/shift step pairs (subtract on the last add), then holds DONE until Run drops.
module mult_control_unit #(
  parameter int N_BITS = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_run,
  input  logic i_clear_a_load_b,
  input  logic i_m,
  output logic o_clr_xa,
  output logic o_ld_b,
  output logic o_add_en,
  output logic o_fn,
  output logic o_shift_en,
  output logic o_busy,
  output logic o_done
);

  localparam int CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_last_step;

  assign w_last_step = (r_cnt == LAST_STEP);

  // State and step-counter registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and strobe decode; only ADD looks at M, so the strobes stay mutually exclusive
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_clr_xa    = 1'b0;
    o_ld_b      = 1'b0;
    o_add_en    = 1'b0;
    o_fn        = 1'b0;
    o_shift_en  = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_clr_xa = i_clear_a_load_b;
        o_ld_b   = i_clear_a_load_b;
        if (i_run) begin
          w_state_nxt = S_CLR;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLR: begin
        o_clr_xa    = 1'b1;
        o_busy      = 1'b1;
        w_cnt_nxt   = CNT_ZERO;
        w_state_nxt = S_ADD;
      end
      S_ADD: begin
        o_busy      = 1'b1;
        o_add_en    = i_m;
        o_fn        = i_m & w_last_step;
        w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        o_busy     = 1'b1;
        o_shift_en = 1'b1;
        // Leaving at the last step keeps cnt from wrapping and stops at exactly N shifts
        if (w_last_step) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_ONE;
          w_state_nxt = S_ADD;
        end
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_run) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_control_unit.sv
// Directed testbench for mult_control_unit: reset, idle clear/load, full
// operations for several multipliers, Run hold, and reset mid-operation.
module tb_mult_control_unit;

  logic clk;
  logic reset;
  logic run;
  logic clab;
  logic m;
  logic clr_xa, ld_b, add_en, fn, shift_en, busy, done;
  logic [6:0] vec;

  int n_cmp;
  int n_err;

  // vec bit order: {clr_xa, ld_b, add_en, fn, shift_en, busy, done}
  assign vec = {clr_xa, ld_b, add_en, fn, shift_en, busy, done};

  mult_control_unit #(.N_BITS(8)) dut (
    .i_clk            (clk),
    .i_reset          (reset),
    .i_run            (run),
    .i_clear_a_load_b (clab),
    .i_m              (m),
    .o_clr_xa         (clr_xa),
    .o_ld_b           (ld_b),
    .o_add_en         (add_en),
    .o_fn             (fn),
    .o_shift_en       (shift_en),
    .o_busy           (busy),
    .o_done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; clab = 1'b0; m = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (vec !== 7'b0000000) begin
      n_err++;
      $display("FAIL reset_idle: got %b expected %b", vec, 7'b0000000);
    end
    @(posedge clk); #2;
    n_cmp++;
    if (vec !== 7'b0000000) begin
      n_err++;
      $display("FAIL reset_idle_hold: got %b expected %b", vec, 7'b0000000);
    end
  endtask

  task automatic test_clear_load();
    @(posedge clk); #1;
    clab = 1'b1;
    #1;
    n_cmp++;
    if (vec !== 7'b1100000) begin
      n_err++;
      $display("FAIL idle_clear_load: got %b expected %b", vec, 7'b1100000);
    end
    @(posedge clk); #1;
    clab = 1'b0;
    #1;
    n_cmp++;
    if (vec !== 7'b0000000) begin
      n_err++;
      $display("FAIL idle_after_clear_load: got %b expected %b", vec, 7'b0000000);
    end
  endtask

  // One full operation; noise pulses ClearA_LoadB throughout the busy/done phase
  task automatic test_mult(input logic [7:0] b, input logic noise,
                           input int exp_adds, input int exp_fns, input string name);
    int adds, fns, shifts, clrs, step;
    logic [6:0] exp;
    adds = 0; fns = 0; shifts = 0; clrs = 0;
    @(posedge clk); #1;
    run = 1'b1; clab = 1'b0; m = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(posedge clk); #1;
      clab = noise;
      if (c >= 2 && c <= 17 && (c % 2) == 0) m = b[(c - 2) / 2];
      else m = 1'b1;
      #1;
      exp = 7'b0000000;
      if (c == 1) begin
        exp = 7'b1000010;
      end else if (c <= 17) begin
        step = (c - 2) / 2;
        exp[1] = 1'b1;
        if ((c % 2) == 0) begin
          exp[4] = b[step];
          exp[3] = b[step] && (step == 7);
        end else begin
          exp[2] = 1'b1;
        end
      end else begin
        exp = 7'b0000001;
      end
      n_cmp++;
      if (vec !== exp) begin
        n_err++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, c, vec, exp);
      end
      clrs   += int'(clr_xa);
      adds   += int'(add_en);
      fns    += int'(fn);
      shifts += int'(shift_en);
    end
    run = 1'b0; clab = 1'b0; m = 1'b0;
    @(posedge clk); #2;
    n_cmp++;
    if (vec !== 7'b0000000) begin
      n_err++;
      $display("FAIL %s back_to_idle: got %b expected %b", name, vec, 7'b0000000);
    end
    n_cmp++;
    if (clrs != 1 || adds != exp_adds || fns != exp_fns || shifts != 8) begin
      n_err++;
      $display("FAIL %s counts: got clr=%0d add=%0d fn=%0d shift=%0d expected clr=1 add=%0d fn=%0d shift=8",
               name, clrs, adds, fns, shifts, exp_adds, exp_fns);
    end
  endtask

  task automatic test_run_hold();
    int clrs, adds, shifts;
    clrs = 0; adds = 0; shifts = 0;
    @(posedge clk); #1;
    run = 1'b1; m = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #2;
      clrs   += int'(clr_xa);
      adds   += int'(add_en);
      shifts += int'(shift_en);
      if (c >= 18) begin
        n_cmp++;
        if (vec !== 7'b0000001) begin
          n_err++;
          $display("FAIL run_hold_done cycle %0d: got %b expected %b", c, vec, 7'b0000001);
        end
      end
    end
    n_cmp++;
    if (clrs != 1 || adds != 8 || shifts != 8) begin
      n_err++;
      $display("FAIL run_hold_counts: got clr=%0d add=%0d shift=%0d expected clr=1 add=8 shift=8",
               clrs, adds, shifts);
    end
    run = 1'b0;
    @(posedge clk); #2;
    n_cmp++;
    if (vec !== 7'b0000000) begin
      n_err++;
      $display("FAIL run_hold_release: got %b expected %b", vec, 7'b0000000);
    end
  endtask

  task automatic test_reset_mid_op();
    int strobes;
    strobes = 0;
    @(posedge clk); #1;
    run = 1'b1; m = 1'b1;
    // Cycle 9 is the step-3 SHIFT
    repeat (9) @(posedge clk);
    #2;
    n_cmp++;
    if (vec !== 7'b0000110) begin
      n_err++;
      $display("FAIL mid_op_step3_shift: got %b expected %b", vec, 7'b0000110);
    end
    reset = 1'b1; run = 1'b0;
    @(posedge clk); #2;
    n_cmp++;
    if (vec !== 7'b0000000) begin
      n_err++;
      $display("FAIL mid_op_reset: got %b expected %b", vec, 7'b0000000);
    end
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      m = ~m;
      #1;
      strobes += int'(clr_xa) + int'(ld_b) + int'(add_en) + int'(shift_en) + int'(busy) + int'(done);
    end
    n_cmp++;
    if (strobes != 0) begin
      n_err++;
      $display("FAIL mid_op_no_strobes: got %0d expected 0", strobes);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_clear_load();
    test_mult(8'hFD, 1'b0, 7, 1, "mult_fd");
    test_mult(8'h00, 1'b0, 0, 0, "mult_00");
    test_mult(8'h80, 1'b0, 1, 1, "mult_80");
    test_mult(8'h5A, 1'b1, 4, 0, "mult_5a_clab_noise");
    test_run_hold();
    test_mult(8'hFD, 1'b0, 7, 1, "mult_second_press");
    test_reset_mid_op();
    test_mult(8'h81, 1'b1, 2, 1, "mult_after_reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
